approx_lut_arbiter: RTL

APPROX_LUT_ARBITER -- requirements
Module: approx_lut_arbiter

---
 rtl/approx_lut_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/approx_lut_arbiter.sv
// Round-robin arbiter in front of a single lower-part-OR approximate adder.
// One operation in flight: IDLE grants and captures, CALC computes, RESP holds until consumed.
module approx_lut_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int KW  = ($clog2(W + 1) > 4) ? $clog2(W + 1) : 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*4-1:0] req_k,
    input  logic              cfg_exact,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IW-1:0]     resp_id,
    output logic [W:0]        resp_sum,
    output logic [15:0]       approx_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_rr_ptr;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [KW-1:0]    r_k;
    logic [IW-1:0]    r_id;
    logic             r_resp_valid;
    logic [IW-1:0]    r_resp_id;
    logic [W:0]       r_resp_sum;
    logic [15:0]      r_approx_cnt;

    logic [NREQ-1:0]  w_rot;
    logic             w_found;
    logic [IW-1:0]    w_grant;
    logic [IW:0]      w_cand;
    logic [IW-1:0]    w_next_ptr;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic [3:0]       w_sel_k;
    logic [KW-1:0]    w_k_eff;

    // Rotate the valids so bit 0 is rr_ptr; the first set bit is the grant offset.
    always_comb begin
        w_rot   = NREQ'({req_valid, req_valid} >> r_rr_ptr);
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!w_found && w_rot[off]) begin
                w_found = 1'b1;
                w_cand  = {1'b0, r_rr_ptr} + (IW + 1)'(off);
                if (int'(w_cand) >= NREQ) begin
                    w_cand = w_cand - (IW + 1)'(NREQ);
                end
                w_grant = w_cand[IW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && r_state == S_IDLE && w_found) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_next_ptr = (int'(w_grant) == NREQ - 1) ? '0 : w_grant + 1'b1;
    assign w_sel_a    = W'(req_a >> (int'(w_grant) * W));
    assign w_sel_b    = W'(req_b >> (int'(w_grant) * W));
    assign w_sel_k    = 4'(req_k >> (int'(w_grant) * 4));

    always_comb begin
        if (cfg_exact) begin
            w_k_eff = '0;
        end else if (int'(w_sel_k) > W) begin
            w_k_eff = KW'(W);
        end else begin
            w_k_eff = KW'(w_sel_k);
        end
    end

    logic [W:0] w_lo_mask;
    logic [W:0] w_lo;
    logic [W:0] w_and_sh;
    logic       w_cin;
    logic [W:0] w_hi_a;
    logic [W:0] w_hi_b;
    logic [W:0] w_hi_sum;
    logic [W:0] w_sum;

    // Bits below K are OR'd; the carry into the exact upper adder is a[K-1]&b[K-1].
    always_comb begin
        w_lo_mask = ~({(W + 1){1'b1}} << r_k);
        w_lo      = ({1'b0, r_a} | {1'b0, r_b}) & w_lo_mask;
        w_and_sh  = {1'b0, r_a & r_b} >> (r_k - 1'b1);
        w_cin     = (r_k != '0) & w_and_sh[0];
        w_hi_a    = {1'b0, r_a} >> r_k;
        w_hi_b    = {1'b0, r_b} >> r_k;
        w_hi_sum  = w_hi_a + w_hi_b + (W + 1)'(w_cin);
        w_sum     = (w_hi_sum << r_k) | w_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_k          <= '0;
            r_id         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_sum   <= '0;
            r_approx_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_k      <= w_k_eff;
                        r_id     <= w_grant;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_resp_sum   <= w_sum;
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        if (r_k != '0 && r_approx_cnt != 16'hFFFF) begin
                            r_approx_cnt <= r_approx_cnt + 16'd1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_sum   = r_resp_sum;
    assign approx_cnt = r_approx_cnt;
    assign dbg_state  = r_state;

endmodule
